// File: rtl/simon_autoplayer.sv
// Automated Simon player: samples the game's mode/pattern LEDs, records Playback
// sequences, replays them in Repeat and drives debounced-length pclk presses.
module simon_autoplayer #(
    parameter int unsigned HOLD_CYCLES = 1000000,
    parameter int unsigned MAX_LEN     = 64
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic       enable,
    input  logic       inject_err,
    input  logic [3:0] pattern_leds,
    input  logic [2:0] mode_leds,
    output logic [3:0] pattern,
    output logic       pclk,
    output logic [6:0] seq_len,
    output logic       done,
    output logic       error
);

    localparam int unsigned IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [2:0] MODE_INPUT  = 3'b001;
    localparam logic [2:0] MODE_PLAY   = 3'b010;
    localparam logic [2:0] MODE_REPEAT = 3'b100;
    localparam logic [2:0] MODE_DONE   = 3'b111;

    typedef enum logic [2:0] {IDLE, SAMPLE, SETUP, PRESS, RELEASE, DONE, ERROR} state_e;

    state_e          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [7:0]      lfsr, lfsr_n;
    logic [6:0]      rec_cnt, rec_cnt_n;
    logic [IW-1:0]   rep_idx, rep_idx_n;
    logic            inj, inj_n;
    logic [3:0]      pattern_n;
    logic            buf_we;
    logic            hold_end;
    logic [3:0]      seq_buf [MAX_LEN];

    assign hold_end = (cnt == CW'(HOLD_CYCLES - 1));
    assign seq_len  = rec_cnt;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        lfsr_n    = lfsr;
        rec_cnt_n = rec_cnt;
        rep_idx_n = rep_idx;
        pattern_n = pattern;
        buf_we    = 1'b0;
        inj_n     = inj | inject_err;
        case (state)
            IDLE: begin
                if (enable) state_n = SAMPLE;
            end
            SAMPLE: begin
                cnt_n = '0;
                case (mode_leds)
                    MODE_INPUT: begin
                        pattern_n = (lfsr[3:0] == 4'h0) ? 4'h1 : lfsr[3:0];
                        lfsr_n    = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
                        rec_cnt_n = '0;
                        state_n   = SETUP;
                    end
                    MODE_PLAY: begin
                        if (rec_cnt == 7'(MAX_LEN)) begin
                            state_n = ERROR;
                        end else begin
                            buf_we    = 1'b1;
                            rec_cnt_n = rec_cnt + 7'd1;
                            rep_idx_n = '0;
                            state_n   = SETUP;
                        end
                    end
                    MODE_REPEAT: begin
                        pattern_n = seq_buf[rep_idx] ^ {3'b000, inj};
                        // a pulse arriving on the consuming cycle re-arms the flag
                        inj_n     = inject_err;
                        rep_idx_n = (rep_idx == IW'(MAX_LEN - 1)) ? '0 : rep_idx + 1'b1;
                        state_n   = SETUP;
                    end
                    MODE_DONE: state_n = DONE;
                    default:   state_n = ERROR;
                endcase
            end
            SETUP: begin
                if (hold_end) begin
                    cnt_n   = '0;
                    state_n = PRESS;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            PRESS: begin
                if (hold_end) begin
                    cnt_n   = '0;
                    state_n = RELEASE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RELEASE: begin
                if (hold_end) begin
                    cnt_n   = '0;
                    state_n = enable ? SAMPLE : IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DONE:    state_n = DONE;
            ERROR:   state_n = ERROR;
            default: state_n = IDLE;
        endcase
    end

    // Outputs decode the next state so they line up with the state they describe.
    always_ff @(posedge sysclk) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            lfsr    <= 8'hA5;
            rec_cnt <= '0;
            rep_idx <= '0;
            inj     <= 1'b0;
            pattern <= '0;
            pclk    <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            lfsr    <= lfsr_n;
            rec_cnt <= rec_cnt_n;
            rep_idx <= rep_idx_n;
            inj     <= inj_n;
            pattern <= pattern_n;
            pclk    <= (state_n == PRESS);
            done    <= (state_n == DONE);
            error   <= (state_n == ERROR);
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst && buf_we) seq_buf[rec_cnt[IW-1:0]] <= pattern_leds;
    end

endmodule
